seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx_if.sv | 26 ++
 rtl/seq_pattern_tx.sv | 141 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-line bundle for seq_pattern_tx.
// master: the controller that launches bursts and watches the line.
// slave : the transmitter itself.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             use_def;
  logic [PAT_W-1:0] pat;
  logic [CNT_W-1:0] rpt;
  logic             dout;
  logic             dout_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, use_def, pat, rpt,
    input  dout, dout_vld, busy, done
  );

  modport slave (
    input  start, use_def, pat, rpt,
    output dout, dout_vld, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a PAT_W-bit pattern out MSB-first,
// repeated rpt times (0 counts as 1), then pulses done for one cycle.
// Optional feature macro: GAP_INSERT_EN inserts GAP_LEN idle cycles
// between consecutive repetitions (never after the last one). Without the
// macro the GAP state and the GAP_LEN parameter do not exist.
// All outputs are registered from the next-state values, so the first bit
// appears in the cycle right after the accepting edge.
module seq_pattern_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = 'b1001,
  parameter int               CNT_W   = 8
`ifdef GAP_INSERT_EN
  ,
  parameter int               GAP_LEN = 2
`endif
) (
  input  logic             clk,
  input  logic             rst,
  seq_pattern_tx_if.slave  bus
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef GAP_INSERT_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LEN - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef GAP_INSERT_EN
    ,
    S_GAP   = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;       // bit currently on the line
  logic [CNT_W-1:0] cnt_q, cnt_d;       // repetitions left, including current
  logic [PAT_W-1:0] shadow_q, shadow_d; // pattern frozen at accept time
`ifdef GAP_INSERT_EN
  logic [GAP_W-1:0] gap_q, gap_d;       // idle cycles left in this gap, minus one
`endif

  logic dout_q, vld_q, busy_q, done_q;
  logic dout_d, vld_d, busy_d, done_d;

  // Next-state logic: walk the pattern, count repetitions, pick outputs.
  always_comb begin
    // NOTE: every variable gets a default here so no path holds a stale value (no latch).
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
`ifdef GAP_INSERT_EN
    gap_d    = gap_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shadow_d = bus.use_def ? DEF_PAT : bus.pat;
          cnt_d    = (bus.rpt == '0) ? CNT_ONE : bus.rpt;
          idx_d    = IDX_MAX;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else if (cnt_q > CNT_ONE) begin
          cnt_d = cnt_q - 1'b1;
          idx_d = IDX_MAX;
`ifdef GAP_INSERT_EN
          gap_d   = GAP_MAX;
          state_d = S_GAP;
`endif
        end else begin
          state_d = S_DONE;
        end
      end

`ifdef GAP_INSERT_EN
      S_GAP: begin
        if (gap_q == '0) state_d = S_SHIFT;
        else             gap_d   = gap_q - 1'b1;
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs describe the state we are about to enter, then get registered.
    vld_d  = (state_d == S_SHIFT);
    dout_d = vld_d ? shadow_d[idx_d] : 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, counters, shadow pattern and output registers; reset aborts a burst.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
`ifdef GAP_INSERT_EN
      gap_q    <= '0;
`endif
      dout_q   <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
`ifdef GAP_INSERT_EN
      gap_q    <= gap_d;
`endif
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx. A reference model expands each
// accepted burst into its expected per-cycle line trace (bits, gaps, done,
// trailing idle) and the bench compares the DUT against it cycle by cycle.
// Builds with or without GAP_INSERT_EN (default GAP_LEN of 2 assumed).
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam logic [PAT_W-1:0] DEF_PAT = 4'b1001;
`ifdef GAP_INSERT_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  typedef struct packed {
    logic dout;
    logic vld;
    logic busy;
    logic done;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   fails     = 0;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.dout = bus.dout;
    o.vld  = bus.dout_vld;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  // Runs one burst whose start is already being driven. Model: rpt reps of
  // the pattern MSB-first, GAP idle-busy cycles between reps, one done
  // cycle, then one idle cycle. If scramble is set, inputs are randomised
  // while busy (including stray start pulses) and restored before idle.
  task automatic run_burst(input string name, input bit hold, input bit scramble,
                           output string bits, output int done_cyc);
    obs_t             exp_q[$];
    obs_t             e, a;
    logic             u0 = bus.use_def;
    logic [PAT_W-1:0] p0 = bus.pat;
    logic [CNT_W-1:0] r0 = bus.rpt;
    logic [PAT_W-1:0] p  = u0 ? DEF_PAT : p0;
    int               reps = (r0 == 0) ? 1 : int'(r0);

    for (int r = 0; r < reps; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back('{p[b], 1'b1, 1'b1, 1'b0});
      if (r < reps - 1)
        for (int g = 0; g < GAP; g++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    end
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});

    bits     = "";
    done_cyc = -1;
    step();                       // accepting edge
    if (!hold) bus.start = 1'b0;

    for (int c = 0; c < exp_q.size(); c++) begin
      e = exp_q[c];
      a = sample();
      tests_run++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got {dout,vld,busy,done}=%b expected %b",
                 name, c + 1, a, e);
      end
      if (a.vld === 1'b1) bits = {bits, (a.dout === 1'b1) ? "1" : "0"};
      if (a.done === 1'b1 && done_cyc < 0) done_cyc = c + 1;
      if (scramble) begin
        if (e.busy) begin
          bus.use_def = 1'($urandom);
          bus.pat     = PAT_W'($urandom);
          bus.rpt     = CNT_W'($urandom);
          if (!hold) bus.start = 1'($urandom);
        end else begin
          bus.use_def = u0;
          bus.pat     = p0;
          bus.rpt     = r0;
          if (!hold) bus.start = 1'b0;
        end
      end
      if (c < exp_q.size() - 1) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.use_def = 1'b0; bus.pat = '0; bus.rpt = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (sample() !== obs_t'(4'b0000)) begin
        fails++;
        $display("FAIL reset cycle %0d: got %b expected 0000", i, sample());
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_default_pattern();
    string bits; int dc;
    bus.use_def = 1'b1; bus.rpt = 8'd1; bus.start = 1'b1;
    run_burst("default_rpt1", 1'b0, 1'b0, bits, dc);
    tests_run++;
    if (dc !== 5) begin fails++; $display("FAIL default_done_cycle: got %0d expected 5", dc); end
  endtask

  task automatic test_user_rpt0();
    string bits; int dc;
    step();
    bus.use_def = 1'b0; bus.pat = 4'b1101; bus.rpt = 8'd0; bus.start = 1'b1;
    run_burst("user_rpt0", 1'b0, 1'b0, bits, dc);
    tests_run++;
    if (bits != "1101") begin fails++; $display("FAIL user_rpt0_bits: got %s expected 1101", bits); end
  endtask

  task automatic test_detector_loop();
    string bits; int dc; int hits = 0; logic [3:0] win = '0;
    step();
    bus.use_def = 1'b1; bus.pat = 4'b0110; bus.rpt = 8'd3; bus.start = 1'b1;
    run_burst("detector_loop", 1'b0, 1'b0, bits, dc);
    for (int i = 0; i < bits.len(); i++) begin
      win = {win[2:0], bits[i] == "1"};
      if (i >= 3 && win == 4'b1001) hits++;
    end
    tests_run++;
    if (bits != "100110011001") begin fails++; $display("FAIL loop_bits: got %s expected 100110011001", bits); end
    tests_run++;
    if (hits != 3) begin fails++; $display("FAIL loop_detections: got %0d expected 3", hits); end
    tests_run++;
    if (dc != 3 * PAT_W + 2 * GAP + 1) begin
      fails++; $display("FAIL loop_done_cycle: got %0d expected %0d", dc, 3 * PAT_W + 2 * GAP + 1);
    end
  endtask

  task automatic test_mid_reset();
    string bits; int dc; obs_t a;
    step();
    bus.use_def = 1'b1; bus.rpt = 8'd4; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    // advance to the second bit of the second repetition
    for (int c = 1; c < PAT_W + GAP + 2; c++) step();
    tests_run++;
    if (bus.dout_vld !== 1'b1) begin fails++; $display("FAIL midrst_pre_vld: got %b expected 1", bus.dout_vld); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    a = sample();
    tests_run++;
    if (a !== obs_t'(4'b0000)) begin fails++; $display("FAIL midrst_abort: got %b expected 0000", a); end
    bus.start = 1'b1;
    run_burst("after_reset", 1'b0, 1'b0, bits, dc);
  endtask

  task automatic test_back_to_back();
    string bits; int dc;
    step();
    bus.use_def = 1'b0; bus.pat = 4'b1011; bus.rpt = 8'd2; bus.start = 1'b1;
    run_burst("b2b_first", 1'b1, 1'b1, bits, dc);
    run_burst("b2b_second", 1'b1, 1'b1, bits, dc);
    tests_run++;
    if (bits != "10111011") begin fails++; $display("FAIL b2b_bits: got %s expected 10111011", bits); end
    bus.start = 1'b0;
  endtask

  task automatic test_random();
    string bits; int dc;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.use_def = 1'($urandom);
      bus.pat     = PAT_W'($urandom);
      bus.rpt     = CNT_W'($urandom_range(0, 5));
      bus.start   = 1'b1;
      run_burst($sformatf("random_%0d", i), 1'b0, 1'b1, bits, dc);
    end
  endtask

  task automatic test_max_rpt();
    string bits; int dc;
    step();
    bus.use_def = 1'b1; bus.rpt = 8'hFF; bus.start = 1'b1;
    run_burst("max_rpt", 1'b0, 1'b0, bits, dc);
    tests_run++;
    if (bits.len() != 255 * PAT_W) begin
      fails++; $display("FAIL max_rpt_len: got %0d expected %0d", bits.len(), 255 * PAT_W);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.use_def = 1'b0; bus.pat = '0; bus.rpt = '0;
    test_reset();
    test_default_pattern();
    test_user_rpt0();
    test_detector_loop();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_max_rpt();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
